// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types and constants
// Holds the converter FSM state encoding, ALU ctrl opcodes and default widths.
package calc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;
  localparam int RES_W = 7;
  localparam int BCD_D = 3;
endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3: double-dabble add-3 cell
// Ports: d - BCD nibble before shift; q - d+3 when d>=5, else d.
module bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: iterative double-dabble binary-to-BCD converter for the ALU result
// Ports: clk/rst_n (sync, active low); in_valid/in_ready/in_data - result input handshake;
//        out_valid/out_ready - output handshake; bcd - D packed digits, units in [3:0];
//        sign - negative flag, only driven when NEG_SIGN_EN is defined (else 0).
// Macro NEG_SIGN_EN: treat in_data as two's complement and convert its magnitude.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int W = RES_W,
  parameter int D = BCD_D
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] bcd,
  output logic           sign
);
  localparam int SW = 4*D + W;
  localparam int CW = $clog2(W + 1);
  if (10**D <= 2**W - 1) begin : g_chk
    $error("result_bcd_converter: D digits cannot hold 2^W-1");
  end
  state_t state, state_d;
  logic [SW-1:0] sr, adj, nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] mag;
  logic load, last, fin;
  assign load = state == IDLE && in_valid;
  assign last = cnt == CW'(W - 1);
  assign fin = state == SHIFT && last;
  // Binary part passes through; each digit nibble is corrected before the shift.
  assign adj[W-1:0] = sr[W-1:0];
  for (genvar i = 0; i < D; i++) begin : g_adj
    bcd_adj3 u_adj (.d(sr[W+4*i +: 4]), .q(adj[W+4*i +: 4]));
  end
  assign nxt = adj << 1;
`ifdef NEG_SIGN_EN
  logic sgn;
  // -2^(W-1) negates to itself, which reads correctly as unsigned 2^(W-1).
  assign mag = in_data[W-1] ? -in_data : in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sgn <= 1'b0;
      sign <= 1'b0;
    end else begin
      if (load) sgn <= in_data[W-1];
      if (fin) sign <= sgn;
    end
  end
`else
  assign mag = in_data;
  assign sign = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_d = load ? SHIFT : fin ? DONE : (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      bcd <= '0;
    end else if (load) begin
      sr <= {{4*D{1'b0}}, mag};
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr <= nxt;
      cnt <= cnt + 1'b1;
      if (last) bcd <= nxt[SW-1:W];
    end
  end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: scoreboard bench for result_bcd_converter
// Define NEG_SIGN_EN for both bench and design to exercise the signed build.
module tb_result_bcd_converter;
  localparam int W = 7;
  localparam int D = 3;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, sign;
  logic [4*D-1:0] bcd;
  int checks = 0, failures = 0, cyc = 0;
  logic [4*D:0] expq[$];
  int accq[$];
  int rises[$];
  logic ovp = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  result_bcd_converter #(.W(W), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .sign(sign)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] v, input logic [4*D:0] e, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) bad("send_timeout");
    in_valid = 1'b1;
    in_data = v;
    if (push) begin
      expq.push_back(e);
      accq.push_back(cyc + 1);
    end
    step();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (expq.size() > 0) bad("drain_timeout");
  endtask
  // Monitor: latency checked on each rising out_valid, result popped on each output handshake.
  always @(negedge clk) begin
    if (out_valid && !ovp) begin
      rises.push_back(cyc);
      if (accq.size() == 0) bad("unexpected_output");
      else chk("latency", cyc - accq.pop_front(), W);
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) bad("extra_handshake");
      else chk("result", {sign, bcd}, expq.pop_front());
    end
    ovp <= out_valid;
  end
`ifdef NEG_SIGN_EN
  logic [W-1:0] vv[4] = '{7'd0, 7'b1111100, 7'b1000000, 7'd63};
  logic [4*D:0] ve[4] = '{13'h0000, 13'h1004, 13'h1064, 13'h0063};
  localparam logic [4*D:0] E64 = 13'h1064;
  localparam logic [4*D:0] E99 = 13'h1029;
`else
  logic [W-1:0] vv[4] = '{7'd0, 7'd127, 7'd100, 7'd9};
  logic [4*D:0] ve[4] = '{13'h0000, 13'h0127, 13'h0100, 13'h0009};
  localparam logic [4*D:0] E64 = 13'h0064;
  localparam logic [4*D:0] E99 = 13'h0099;
`endif
  initial begin
    int n;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_sign", sign, 0);
    rst_n = 1'b1;
    foreach (vv[i]) send(vv[i], ve[i], 1'b1);
    drain();
    out_ready = 1'b0;
    send(7'd42, 13'h0042, 1'b1);
    chk("bcd_hold_shift", bcd, 32'(ve[3][4*D-1:0]));
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) bad("done_timeout");
    in_valid = 1'b1;
    in_data = 7'd5;
    repeat (5) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_bcd", bcd, 12'h042);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    expq.push_back(13'h0005);
    accq.push_back(cyc + 2);
    step();
    chk("idle_after_done", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("accepted_late", in_ready, 0);
    drain();
    send(7'd88, '0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_bcd", bcd, 0);
    rst_n = 1'b1;
    send(7'd64, E64, 1'b1);
    drain();
    rises.delete();
    send(7'd3, 13'h0003, 1'b1);
    send(7'd56, 13'h0056, 1'b1);
    send(7'd99, E99, 1'b1);
    drain();
    step();
    chk("b2b_pulses", rises.size(), 3);
    if (rises.size() == 3) begin
      chk("b2b_gap1", rises[1] - rises[0], 9);
      chk("b2b_gap2", rises[2] - rises[1], 9);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Sequential binary-to-BCD converter that sits downstream of the calculator ALU result bus `o`.
- Accepts one W-bit result per valid/ready handshake and converts it with iterative double-dabble, one bit per clock.
- Presents D packed BCD digits to the display / seven-segment stage.

Parameters:
- W, 7: input result width; matches the ALU output `o`.
- D, 3: number of BCD output digits; 10^D must exceed 2^W-1, otherwise elaboration fails.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  `in_data` holds a result to convert
- in_ready  output  1  block can accept a result
- in_data  input  W  ALU result
- out_valid  output  1  `bcd` / `sign` hold a completed conversion
- out_ready  input  1  consumer accepts the completed conversion
- bcd  output  4*D  packed digits; [3:0] = units, [7:4] = tens, ...
- sign  output  1  negative flag; constant 0 unless NEG_SIGN_EN

Behaviour:
- Reset: rst_n sampled low at a clk edge forces:
  - state IDLE; in_ready=1; out_valid=0; bcd=0; sign=0
  - shift register and bit counter cleared
  - any in-progress conversion is abandoned; reset applies in any state.
- States:
  - IDLE: in_ready=1.
    - in_valid=1 at an edge: load shift register = {4*D zeros, in_data}, counter=0, go to SHIFT.
  - SHIFT: in_ready=0.
    - Each edge: every BCD nibble >=5 gets +3 (all nibbles in parallel, using pre-shift values), then the whole register shifts left 1 and the counter increments.
    - After the W-th shift: latch the upper 4*D bits into `bcd`, go to DONE.
  - DONE: out_valid=1; `bcd` and `sign` held stable.
    - out_ready=1 at an edge: out_valid->0, go to IDLE.
- Latency: acceptance at edge N -> out_valid high from edge N+W (7 cycles at defaults).
- Throughput: one result per W+2 cycles, best case.
- in_data is sampled only on the acceptance edge; later changes are ignored.
- in_valid is ignored outside IDLE; no queueing, no drop indication.
- DONE with out_ready=1 and in_valid=1 in the same cycle: only the output handshake completes; the new input is accepted in the following IDLE cycle.
- out_ready held high continuously: out_valid is a one-cycle pulse.
- bcd holds its last value while in IDLE/SHIFT; it updates only on entry to DONE.
- Digits are always 0..9; no overflow is possible under the parameter constraint.
- Counter width: clog2(W+1) bits.

Optional Feature:
- Macro: NEG_SIGN_EN
- Defined:
  - in_data is treated as W-bit two's complement (ALU subtract can go negative).
  - On load, sign = in_data[W-1]; the shift register is loaded with the magnitude (two's-complement negate if negative).
  - The most negative value -2^(W-1) converts to magnitude 2^(W-1) (W-bit unsigned).
  - sign is latched with bcd on entry to DONE.
- Undefined:
  - in_data is unsigned; sign is tied to 0; no negate logic is present.

Decomposition:
- Package calc_pkg:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - ALU ctrl opcode constants (ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11)
  - default widths RES_W=7, BCD_D=3
- Sub-module bcd_adj3:
  - combinational 4-bit cell: out = in>=5 ? in+3 : in
  - instantiated D times via generate.

Test Plan:
- Reset, then in_data=7'd0 with in_valid pulse -> out_valid after 7 cycles, bcd=12'h000, sign=0.
- in_data=7'd127 -> bcd=12'h127; in_data=7'd100 -> bcd=12'h100; in_data=7'd9 -> bcd=12'h009.
- out_ready held 0 for 5 cycles after completion -> out_valid and bcd=12'h042 (input 42) stable throughout. in_valid asserted meanwhile with 7'd5 -> in_ready stays 0 and the value is not accepted. out_ready=1 -> IDLE, then 5 is accepted and converts to 12'h005.
- Start 7'd88, assert rst_n=0 at the 3rd SHIFT cycle -> next edge: out_valid=0, in_ready=1, bcd=0. New conversion of 7'd64 -> bcd=12'h064 with normal latency.
- Back-to-back inputs 3, 56, 99 with out_ready=1 -> three single-cycle out_valid pulses, bcd 003/056/099 in order, spaced 9 cycles apart.
- NEG_SIGN_EN defined:
  - in_data=7'b1111100 (-4) -> sign=1, bcd=12'h004
  - 7'b1000000 (-64) -> sign=1, bcd=12'h064
  - 7'd63 -> sign=0, bcd=12'h063
